// File: rtl/piso_pkg.sv
// Shared types and constants for the PISO serializer.
// Build with PISO_PARITY_EN defined to add the trailing even-parity state.
package piso_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
`ifdef PISO_PARITY_EN
    SHIFT = 2'd1,
    PAR   = 2'd2
`else
    SHIFT = 2'd1
`endif
  } state_e;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter: first bit one cycle after acceptance, gapless back-to-back words.
// Optional macro PISO_PARITY_EN appends an even-parity bit after each word.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] parallel_in,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               serial_out_q, serial_out_d;
  logic               serial_valid_q, serial_valid_d;
`ifdef PISO_PARITY_EN
  logic               par_q, par_d;
`endif

  logic last_bit;
  logic accept;

  always_comb begin
    // The cycle carrying a word's final bit is also its hand-off window.
`ifdef PISO_PARITY_EN
    last_bit = (state_q == PAR);
`else
    last_bit = (state_q == SHIFT) && (cnt_q == LAST_IDX);
`endif
    in_ready = !rst && ((state_q == IDLE) || last_bit);
    accept   = in_valid && in_ready;

    state_d        = state_q;
    shreg_d        = shreg_q;
    cnt_d          = cnt_q;
    serial_out_d   = 1'b0;
    serial_valid_d = 1'b0;
`ifdef PISO_PARITY_EN
    par_d          = par_q;
`endif

    if (accept) begin
      state_d        = SHIFT;
      cnt_d          = '0;
      serial_valid_d = 1'b1;
`ifdef PISO_PARITY_EN
      par_d          = ^parallel_in;
`endif
      if (MSB_FIRST) begin
        serial_out_d = parallel_in[WIDTH-1];
        shreg_d      = parallel_in << 1;
      end else begin
        serial_out_d = parallel_in[0];
        shreg_d      = parallel_in >> 1;
      end
    end else begin
      case (state_q)
        SHIFT: begin
          if (cnt_q == LAST_IDX) begin
`ifdef PISO_PARITY_EN
            state_d        = PAR;
            serial_out_d   = par_q;
            serial_valid_d = 1'b1;
`else
            state_d        = IDLE;
`endif
          end else begin
            cnt_d          = cnt_q + CNT_W'(1);
            serial_valid_d = 1'b1;
            if (MSB_FIRST) begin
              serial_out_d = shreg_q[WIDTH-1];
              shreg_d      = shreg_q << 1;
            end else begin
              serial_out_d = shreg_q[0];
              shreg_d      = shreg_q >> 1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      shreg_q        <= '0;
      cnt_q          <= '0;
      serial_out_q   <= 1'b0;
      serial_valid_q <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q          <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      shreg_q        <= shreg_d;
      cnt_q          <= cnt_d;
      serial_out_q   <= serial_out_d;
      serial_valid_q <= serial_valid_d;
`ifdef PISO_PARITY_EN
      par_q          <= par_d;
`endif
    end
  end

  assign serial_out   = serial_out_q;
  assign serial_valid = serial_valid_q;
  assign busy         = (state_q != IDLE);
  assign done         = last_bit;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share stimulus and are
// checked each cycle against a queue of expected serial bits built from each accepted word.
module tb_piso_serializer;

  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] parallel_in;

  logic rdy_m, out_m, vld_m, busy_m, done_m;
  logic rdy_l, out_l, vld_l, busy_l, done_l;

  int checks   = 0;
  int failures = 0;

  logic qm[$];
  logic ql[$];

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_m),
    .parallel_in(parallel_in), .serial_out(out_m), .serial_valid(vld_m),
    .busy(busy_m), .done(done_m)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_l),
    .parallel_in(parallel_in), .serial_out(out_l), .serial_valid(vld_l),
    .busy(busy_l), .done(done_l)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare both instances against the heads of their expected-bit queues.
  task automatic check_outputs(input string tag);
    logic ev, eb;
    ev = (qm.size() != 0);
    eb = ev ? qm[0] : 1'b0;
    check({tag, "/m_valid"}, vld_m, ev);
    check({tag, "/m_bit"},   out_m, eb);
    check({tag, "/m_done"},  done_m, qm.size() == 1);
    check({tag, "/m_busy"},  busy_m, ev);
    check({tag, "/m_ready"}, rdy_m, qm.size() <= 1);
    ev = (ql.size() != 0);
    eb = ev ? ql[0] : 1'b0;
    check({tag, "/l_valid"}, vld_l, ev);
    check({tag, "/l_bit"},   out_l, eb);
    check({tag, "/l_done"},  done_l, ql.size() == 1);
    check({tag, "/l_busy"},  busy_l, ev);
    check({tag, "/l_ready"}, rdy_l, ql.size() <= 1);
  endtask

  // One clock: offer (v, w), advance the model, check at the following negedge.
  task automatic step(input string tag, input logic v, input logic [W-1:0] w);
    logic acc;
    logic par;
    in_valid    = v;
    parallel_in = w;
    acc = v && (qm.size() <= 1);
    @(posedge clk);
    if (qm.size() != 0) void'(qm.pop_front());
    if (ql.size() != 0) void'(ql.pop_front());
    if (acc) begin
      par = 1'b0;
      for (int i = 0; i < W; i++) begin
        qm.push_back(w[W-1-i]);
        ql.push_back(w[i]);
        par = par ^ w[i];
      end
      if (NB > W) begin
        qm.push_back(par);
        ql.push_back(par);
      end
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "/outs_m"}, {rdy_m, out_m, vld_m, busy_m, done_m}, 5'b0);
    check({tag, "/outs_l"}, {rdy_l, out_l, vld_l, busy_l, done_l}, 5'b0);
  endtask

  logic [W-1:0] rw;
  int waits;

  initial begin
    rst = 1'b1;
    in_valid = 1'b1;
    parallel_in = 4'b1111;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check_outputs("idle");

    // Single word 1101: MSB 1,1,0,1 and LSB 1,0,1,1, done on the last bit.
    step("w1101", 1'b1, 4'b1101);
    for (int i = 0; i < NB; i++) step("w1101_bits", 1'b0, 4'b0000);
    step("w1101_idle", 1'b0, 4'b0000);

    // Back-to-back: 0110 offered only in the final-bit cycle of 1101.
    step("b2b_first", 1'b1, 4'b1101);
    for (int i = 0; i < NB - 1; i++) step("b2b_mid", 1'b0, 4'b0000);
    step("b2b_second", 1'b1, 4'b0110);
    for (int i = 0; i < NB; i++) step("b2b_bits", 1'b0, 4'b0000);

    // Busy-time offer must be ignored.
    step("busy_acc", 1'b1, 4'b1101);
    step("busy_ign", 1'b1, 4'b0000);
    step("busy_ign", 1'b1, 4'b0000);
    for (int i = 0; i < NB; i++) step("busy_tail", 1'b0, 4'b0000);

    // Reset after bit 2 of 1101.
    step("rst_acc", 1'b1, 4'b1101);
    step("rst_b2", 1'b0, 4'b0000);
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    @(posedge clk);
    @(negedge clk);
    check_all_zero("rst_hold");
    rst = 1'b0;
    qm.delete();
    ql.delete();
    #1;
    check_outputs("rst_release");
    step("post_rst", 1'b0, 4'b0000);

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      rw = W'($urandom);
      step("rand", ($urandom_range(0, 3) != 0), rw);
    end
    waits = 0;
    while (qm.size() != 0 && waits < 20) begin
      step("drain", 1'b0, 4'b0000);
      waits++;
    end
    check("drained", qm.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of data bits per word, minimum 2.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 shifts out bit WIDTH-1 first; 0 shifts out bit 0 first.
REQ-003 SHALL have one clock and an asynchronous, active-high reset; all state SHALL update on the rising edge of clk.
REQ-004 SHALL have port clk  input  1  clock.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port in_valid  input  1  parallel word offered.
REQ-007 SHALL have port in_ready  output  1  serializer can accept a word.
REQ-008 SHALL have port parallel_in  input  WIDTH  word to serialize; it is the output of the upstream PIPO register.
REQ-009 SHALL have port serial_out  output  1  serial data bit, registered.
REQ-010 SHALL have port serial_valid  output  1  serial_out carries a valid bit, registered.
REQ-011 SHALL have port busy  output  1  word in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse coincident with the final serial bit of a word.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT and PAR; PAR exists only under PARITY_EN.
REQ-014 SHALL accept a word on a rising edge where in_valid && in_ready; parallel_in SHALL be sampled only on that edge.
REQ-015 SHALL drive in_ready = 1 in IDLE and during the cycle carrying the final bit of a word; otherwise 0.
REQ-016 SHALL present the first bit of a word on serial_out in the cycle after acceptance, with serial_valid = 1 and latency 1.
REQ-017 SHALL present one bit per cycle for WIDTH consecutive cycles, with no gaps, in the order set by MSB_FIRST.
REQ-018 SHALL use a bit counter of width clog2(WIDTH); it returns to 0 on each word acceptance.
REQ-019 SHALL, on acceptance during the final-bit cycle, present the next word's first bit in the very next cycle, giving a gapless stream.
REQ-020 SHALL, after the final bit without a new acceptance, enter IDLE with serial_valid = 0 and serial_out = 0.
REQ-021 SHALL assert busy in SHIFT and in PAR.
REQ-022 SHALL ignore in_valid while in_ready = 0.

Reset
REQ-023 SHALL, while rst = 1, force: state IDLE, shift register 0, counter 0, serial_out 0, serial_valid 0, busy 0, done 0, in_ready 0.
REQ-024 SHALL, on reset mid-word, abort the word: done is not pulsed, and in_ready = 1 in the first cycle after rst deasserts.

Configuration
REQ-025 SHALL, with macro PISO_PARITY_EN defined, append one even-parity bit (XOR of the accepted word) in state PAR; done and the in_ready window then move to the parity cycle, giving WIDTH+1 bits per word.
REQ-026 SHALL, with PISO_PARITY_EN undefined, emit WIDTH bits per word and contain no parity logic.

Structure
REQ-027 SHALL take the FSM state enum typedef and the DEFAULT_WIDTH constant from shared package piso_pkg.
REQ-028 SHALL be a single module; no sub-module is warranted.

Verification
REQ-029 SHALL verify MSB first: WIDTH=4, MSB_FIRST=1, accept 4'b1101 -> serial_out 1,1,0,1 on cycles +1..+4, serial_valid high for those cycles, done on cycle +4.
REQ-030 SHALL verify LSB first: MSB_FIRST=0, accept 4'b1101 -> serial_out 1,0,1,1.
REQ-031 SHALL verify back-to-back words: 4'b1101, then 4'b0110 accepted in the final-bit cycle -> 8 gapless valid bits 1,1,0,1,0,1,1,0 and two done pulses.
REQ-032 SHALL verify busy-time stimulus is ignored: in_valid = 1 with 4'b0000 during bits 2-3 -> no acceptance and the current word is unchanged.
REQ-033 SHALL verify reset mid-word: rst pulsed after bit 2 of 4'b1101 -> all outputs 0, no done, and in_ready = 1 in the cycle after release.
REQ-034 SHALL verify parity: with PISO_PARITY_EN, 4'b1101 -> serial_out 1,1,0,1,1, with done on the 5th bit.
